soc_bram_wb: RTL and testbench

SOC_BRAM_WB -- requirements
Module: soc_bram_wb

---
 rtl/soc_bram_wb.sv | 94 +++++++++
 tb/tb_soc_bram_wb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bram_wb.sv
`default_nettype none
// soc_bram_wb: Wishbone-style slave bridging to a synchronous BRAM port with 1-cycle read latency.
// Optional macro SOC_BRAM_WB_RDATA_GATE_EN forces wb_rdata to zero whenever wb_ack is low.
module soc_bram_wb #(
  parameter int SIZE  = 256,
  parameter int AW    = $clog2(SIZE),
  parameter int WB_AW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WB_AW-1:0] wb_addr,
  output logic [31:0]      wb_rdata,
  input  logic [31:0]      wb_wdata,
  input  logic [3:0]       wb_wmsk,
  input  logic             wb_we,
  input  logic             wb_cyc,
  output logic             wb_ack,
  output logic [AW-1:0]    bram_addr,
  input  logic [31:0]      bram_rdata,
  output logic [31:0]      bram_wdata,
  output logic [3:0]       bram_wmsk,
  output logic             bram_we
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_CAP  = 2'd2,
    ACK     = 2'd3
  } state_e;

  // One extra bit so SIZE == 2**WB_AW still compares correctly.
  localparam logic [WB_AW:0] SIZE_EXT = (WB_AW+1)'(SIZE);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        in_range;

  assign in_range   = ({1'b0, wb_addr} < SIZE_EXT);
  assign bram_addr  = wb_addr[AW-1:0];
  assign bram_wdata = wb_wdata;
  assign bram_wmsk  = wb_wmsk;

  // rst_n term keeps the strobe low while reset is held with a request pending.
  assign bram_we = wb_cyc & wb_we & in_range & (state_q == IDLE) & rst_n;
  assign wb_ack  = (state_q == ACK);

`ifdef SOC_BRAM_WB_RDATA_GATE_EN
  assign wb_rdata = wb_ack ? rdata_q : 32'h0000_0000;
`else
  assign wb_rdata = rdata_q;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc) begin
          state_d = wb_we ? ACK : RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_d = wb_cyc ? RD_CAP : IDLE;
      end
      RD_CAP: begin
        if (wb_cyc) begin
          state_d = ACK;
          rdata_d = in_range ? bram_rdata : 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_bram_wb.sv
`default_nettype none
// tb_soc_bram_wb: table-driven directed vectors plus abort/reset sequences and a short random run.
module tb_soc_bram_wb;

  logic        clk;
  logic        rst_n;
  logic [15:0] wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_wmsk;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic [7:0]  bram_addr;
  logic [31:0] bram_rdata;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_wmsk;
  logic        bram_we;

  soc_bram_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_addr    (wb_addr),
    .wb_rdata   (wb_rdata),
    .wb_wdata   (wb_wdata),
    .wb_wmsk    (wb_wmsk),
    .wb_we      (wb_we),
    .wb_cyc     (wb_cyc),
    .wb_ack     (wb_ack),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .bram_wdata (bram_wdata),
    .bram_wmsk  (bram_wmsk),
    .bram_we    (bram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM: registered read, byte-masked write.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!bram_wmsk[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end
    end
    bram_rdata <= mem[bram_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] shadow [0:255];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmsk;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hold_exp();
`ifdef SOC_BRAM_WB_RDATA_GATE_EN
    return 32'h0;
`else
    return last_rd;
`endif
  endfunction

  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmsk, input logic [31:0] exp_rd, input int exp_lat,
                         input int exp_we, input string name, input bit rel_rst);
    int n;
    int we_cnt;
    bit got;
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata; wb_wmsk = wmsk;
    if (rel_rst) rst_n = 1'b1;
    n = 0; we_cnt = 0; got = 1'b0;
    while (!got && n <= 8) begin
      #1;
      if (bram_we) we_cnt++;
      if (wb_ack) begin
        got = 1'b1;
      end else begin
        chk({name, "_hold"}, wb_rdata, hold_exp());
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ack required=ack_at_%0d", name, exp_lat);
    end else begin
      chk({name, "_lat"}, n, exp_lat);
      if (!we) begin
        chk({name, "_rdata"}, wb_rdata, exp_rd);
        last_rd = exp_rd;
      end else begin
        chk({name, "_wack_rdata"}, wb_rdata, last_rd);
        if (addr < 16'd256) begin
          for (int b = 0; b < 4; b++) begin
            if (!wmsk[b]) shadow[addr[7:0]][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end
    wb_cyc = 1'b0;
    @(negedge clk);
    #1;
    if (bram_we) we_cnt++;
    chk({name, "_ack_1cyc"}, wb_ack, 0);
    chk({name, "_post_hold"}, wb_rdata, hold_exp());
    chk({name, "_we_cnt"}, we_cnt, exp_we);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'b0000, 32'h0,        1, 1};
    vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'b0000, 32'hDEADBEEF, 3, 0};
    vecs[2]  = '{1'b1, 16'h0010, 32'h11223344, 4'b1010, 32'h0,        1, 1};
    vecs[3]  = '{1'b0, 16'h0010, 32'h0,        4'b0000, 32'hDE22BE44, 3, 0};
    vecs[4]  = '{1'b1, 16'h0100, 32'hFFFFFFFF, 4'b0000, 32'h0,        1, 0};
    vecs[5]  = '{1'b0, 16'h0100, 32'h0,        4'b0000, 32'h00000000, 3, 0};
    vecs[6]  = '{1'b1, 16'h0020, 32'hA5A5A5A5, 4'b0000, 32'h0,        1, 1};
    vecs[7]  = '{1'b1, 16'h0020, 32'hCAFEF00D, 4'b1111, 32'h0,        1, 1};
    vecs[8]  = '{1'b0, 16'h0020, 32'h0,        4'b0000, 32'hA5A5A5A5, 3, 0};
    vecs[9]  = '{1'b1, 16'h00FF, 32'h12345678, 4'b0000, 32'h0,        1, 1};
    vecs[10] = '{1'b0, 16'h00FF, 32'h0,        4'b0000, 32'h12345678, 3, 0};
    vecs[11] = '{1'b1, 16'h0110, 32'h55555555, 4'b0000, 32'h0,        1, 0};
    vecs[12] = '{1'b0, 16'h0010, 32'h0,        4'b0000, 32'hDE22BE44, 3, 0};
    vecs[13] = '{1'b0, 16'hFFFF, 32'h0,        4'b0000, 32'h00000000, 3, 0};
    vecs[14] = '{1'b0, 16'h0030, 32'h0,        4'b0000, 32'h0BADF00D, 3, 0};
    vecs[15] = '{1'b1, 16'h0030, 32'h00FF00FF, 4'b0110, 32'h0,        1, 1};
    vecs[16] = '{1'b0, 16'h0030, 32'h0,        4'b0000, 32'h00ADF0FF, 3, 0};

    // Reset held with a write request already pending.
    rst_n = 1'b0;
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 16'h0030; wb_wdata = 32'h0BADF00D; wb_wmsk = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", wb_ack, 0);
    chk("rst_rdata", wb_rdata, 32'h0);
    chk("rst_bram_we", bram_we, 0);
    run_txn(1'b1, 16'h0030, 32'h0BADF00D, 4'b0000, 32'h0, 1, 1, "rst_release_wr", 1'b1);

    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmsk, vecs[i].exp_rd,
              vecs[i].exp_lat, vecs[i].exp_we, $sformatf("v%0d", i), 1'b0);
    end

    // Abort a read in RD_WAIT, then in RD_CAP.
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 16'h00FF;
      repeat (k) @(negedge clk);
      wb_cyc = 1'b0;
      repeat (4) begin
        @(negedge clk);
        #1;
        chk($sformatf("abort%0d_no_ack", k), wb_ack, 0);
        chk($sformatf("abort%0d_hold", k), wb_rdata, hold_exp());
      end
      run_txn(1'b0, 16'h0010, 32'h0, 4'b0000, 32'hDE22BE44, 3, 0,
              $sformatf("after_abort%0d", k), 1'b0);
    end

    // Asynchronous reset while in RD_CAP.
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 16'h0020;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", wb_ack, 0);
    chk("async_rst_rdata", wb_rdata, 32'h0);
    chk("async_rst_bram_we", bram_we, 0);
    wb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_ack", wb_ack, 0);
      chk("post_rst_rdata", wb_rdata, 32'h0);
    end

    // Random run over addresses already known to the shadow model.
    for (int t = 0; t < 20; t++) begin
      logic [15:0] pool [6];
      logic [15:0] a;
      logic        w;
      logic [31:0] d;
      logic [3:0]  m;
      logic [31:0] e;
      pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0030;
      pool[3] = 16'h00FF; pool[4] = 16'h0100; pool[5] = 16'h01F0;
      a = pool[$urandom_range(0, 5)];
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      e = (a < 16'd256) ? shadow[a[7:0]] : 32'h0;
      run_txn(w, a, d, m, e, w ? 1 : 3, (w && a < 16'd256) ? 1 : 0,
              $sformatf("rnd%0d", t), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
